// File: rtl/mouse_pkg.sv
// mouse_pkg: shared PS/2 mouse decoder types and flag-byte bit positions
package mouse_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam int FLAG_LEFT    = 0;
  localparam int FLAG_ALWAYS1 = 3;
  localparam int FLAG_XSIGN   = 4;
  localparam int FLAG_XOVF    = 6;
  localparam int PKT_BYTES    = 3;
endpackage

// File: rtl/ps2_byte_receiver.sv
// ps2_byte_receiver: synchronises PS/2 pins and deserialises 11-bit frames (odd parity enforced under PS2_PARITY_CHECK_EN)
module ps2_byte_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);
  ps2_state_t state, state_n;
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic parity_bit;
  logic [TW-1:0] timer;
  logic fall, data_bit, timeout, par_ok;
  assign data_bit = dat_sync[1];
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign timeout = (state != IDLE) && (timer == T_LIM);
  assign byte_data = shift;
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift, parity_bit};
`else
  assign par_ok = ^{shift, parity_bit} | 1'b1;
`endif
  // pin synchronisers (idle-high) and previous-clock copy for edge detect
  always_ff @(posedge clock)
    if (reset_) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  // state register, bit shifter and inactivity timer
  always_ff @(posedge clock)
    if (reset_) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      timer      <= '0;
    end else begin
      state <= state_n;
      timer <= (fall || state == IDLE) ? '0 : timer + 1'b1;
      if (fall && !timeout) begin
        if (state == IDLE) bit_cnt <= '0;
        if (state == DATA) begin
          shift   <= {data_bit, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == PARITY) parity_bit <= data_bit;
      end
    end
  // next state and byte handshake; timeout beats a coincident edge
  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    if (timeout) begin
      state_n    = IDLE;
      byte_error = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    state_n = data_bit ? IDLE : DATA;
        DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n    = IDLE;
          byte_valid = data_bit & par_ok;
          byte_error = ~(data_bit & par_ok);
        end
      endcase
    end
  end
endmodule

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder: assembles 3-byte PS/2 mouse packets into a saturating X position and left-button state
module ps2_mouse_decoder
  import mouse_pkg::*;
#(
  parameter int MAX_X          = 639,
  parameter int RESET_X        = 0,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic        mouse_pressed_,
  output logic        packet_valid,
  output logic        frame_error
);
  localparam logic signed [17:0] MAX_S = 18'(MAX_X);
  logic [7:0] byte_data, x_mag;
  logic byte_valid, byte_error;
  logic [1:0] idx;
  logic f_left, f_sign, f_ovf;
  logic signed [17:0] sum;
  logic [15:0] x_next;
  ps2_byte_receiver #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock      (clock),
    .reset_     (reset_),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_error (byte_error)
  );
  // signed delta applied to the current position, clamped to 0..MAX_X
  always_comb begin
    sum    = $signed({2'b00, mouse_x}) + $signed({{10{f_sign}}, x_mag});
    x_next = (sum < 0) ? 16'd0 : (sum > MAX_S) ? MAX_S[15:0] : sum[15:0];
  end
  // packet index, captured flags and output updates on the last byte
  always_ff @(posedge clock)
    if (reset_) begin
      mouse_x        <= 16'(RESET_X);
      mouse_pressed_ <= 1'b0;
      packet_valid   <= 1'b0;
      frame_error    <= 1'b0;
      idx            <= '0;
      f_left         <= 1'b0;
      f_sign         <= 1'b0;
      f_ovf          <= 1'b0;
      x_mag          <= '0;
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= byte_error;
      if (byte_error) idx <= '0;
      else if (byte_valid) begin
        if (idx == 2'd0) begin
          if (byte_data[FLAG_ALWAYS1]) begin
            f_left <= byte_data[FLAG_LEFT];
            f_sign <= byte_data[FLAG_XSIGN];
            f_ovf  <= byte_data[FLAG_XOVF];
            idx    <= 2'd1;
          end
        end else if (idx == 2'd1) begin
          x_mag <= byte_data;
          idx   <= 2'd2;
        end else if (idx == 2'(PKT_BYTES - 1)) begin
          mouse_pressed_ <= f_left;
          if (!f_ovf) mouse_x <= x_next;
          packet_valid <= 1'b1;
          idx          <= '0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder: directed PS/2 packet stimulus with an expected-result queue
module tb_ps2_mouse_decoder;
  typedef struct {int x; bit p;} exp_t;
  logic clock = 1'b0, reset_ = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [15:0] mouse_x;
  logic mouse_pressed_, packet_valid, frame_error;
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  int pv_cnt = 0, fe_cnt = 0, obs_x = 0;
  bit obs_p = 1'b0;
  int model_x = 0, fe_exp = 0;
  bit model_p = 1'b0;

  ps2_mouse_decoder dut (
    .clock          (clock),
    .reset_         (reset_),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .mouse_x        (mouse_x),
    .mouse_pressed_ (mouse_pressed_),
    .packet_valid   (packet_valid),
    .frame_error    (frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (packet_valid) begin
      pv_cnt++;
      obs_x = int'(mouse_x);
      obs_p = mouse_pressed_;
    end
    if (frame_error) fe_cnt++;
  end

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0, input bit stop = 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic push_exp(input logic [7:0] f, input logic [7:0] xm);
    exp_t e;
    int d = f[4] ? int'(xm) - 256 : int'(xm);
    if (!f[6]) model_x = (model_x + d < 0) ? 0 : (model_x + d > 639) ? 639 : model_x + d;
    model_p = f[0];
    e.x = model_x;
    e.p = model_p;
    exp_q.push_back(e);
  endtask

  task automatic await_pkt(input string tag, input int pv0);
    exp_t e;
    for (int i = 0; i < 200 && pv_cnt == pv0; i++) @(negedge clock);
    chk({tag, "_pv"}, pv_cnt, pv0 + 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_x"}, obs_x, e.x);
      chk({tag, "_btn"}, int'(obs_p), int'(e.p));
    end
    chk({tag, "_fe"}, fe_cnt, fe_exp);
  endtask

  task automatic pkt(input logic [7:0] f, input logic [7:0] xm, input string tag);
    int pv0 = pv_cnt;
    push_exp(f, xm);
    send_byte(f);
    send_byte(xm);
    send_byte(8'h00);
    await_pkt(tag, pv0);
  endtask

  initial begin
    int pv0;
    repeat (5) @(negedge clock);
    reset_ = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_x", int'(mouse_x), 0);
    chk("rst_btn", int'(mouse_pressed_), 0);
    chk("rst_pv", int'(packet_valid), 0);
    chk("rst_fe", int'(frame_error), 0);
    pkt(8'h09, 8'h05, "p_plus5");
    pkt(8'h19, 8'hFE, "p_minus2");
    pkt(8'h18, 8'hFB, "p_lowsat");
    for (int i = 0; i < 4; i++) pkt(8'h08, 8'h7F, "p_ramp");
    pkt(8'h08, 8'h7A, "p_to630");
    pkt(8'h08, 8'h7F, "p_highsat");
    pkt(8'h48, 8'h10, "p_ovf");
    pkt(8'h18, 8'h00, "p_minus256");
    send_byte(8'h00);
    pkt(8'h08, 8'h02, "p_resync");
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (5100) @(negedge clock);
    fe_exp++;
    chk("timeout_fe", fe_cnt, fe_exp);
    pkt(8'h08, 8'h01, "p_after_to");
    send_byte(8'h08);
    send_byte(8'h22, 1'b0, 1'b0);
    fe_exp++;
    chk("stop0_fe", fe_cnt, fe_exp);
    pkt(8'h08, 8'h03, "p_after_stop0");
    pv0 = pv_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_byte(8'h08);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00);
    repeat (50) @(negedge clock);
    fe_exp++;
    chk("par_fe", fe_cnt, fe_exp);
    chk("par_pv", pv_cnt, pv0);
    chk("par_x", int'(mouse_x), model_x);
`else
    push_exp(8'h08, 8'h04);
    send_byte(8'h08);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00);
    await_pkt("p_badpar", pv0);
`endif
    chk("final_x", int'(mouse_x), model_x);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_decoder.md
Name: ps2_mouse_decoder

Overview:
- Produces the mouse signals that the cursor/counter logic consumes: `mouse_x` (absolute 16-bit position) and `mouse_pressed_` (left button).
- Receives the raw PS/2 clock/data pair from a mouse, deserialises 11-bit frames and assembles 3-byte movement packets.
- Accumulates signed X deltas into a saturating absolute position.
- Sits between the board PS/2 pins and the cursor-consuming modules, all in the `clock` domain.

Parameters:
- `MAX_X`, 639, upper saturation bound for `mouse_x` (inclusive).
- `RESET_X`, 0, value loaded into `mouse_x` on reset; must be ≤ `MAX_X`.
- `TIMEOUT_CYCLES`, 5000, idle `clock` cycles mid-frame before the byte FSM aborts to IDLE.

Ports:
- `clock`  input  1  system clock
- `reset_`  input  1  synchronous, active-high reset
- `ps2_clk`  input  1  raw PS/2 clock from pin, asynchronous
- `ps2_data`  input  1  raw PS/2 data from pin, asynchronous
- `mouse_x`  output  16  absolute X position, 0..`MAX_X`
- `mouse_pressed_`  output  1  1 while left button is held
- `packet_valid`  output  1  one-cycle pulse when a full 3-byte packet has been applied
- `frame_error`  output  1  one-cycle pulse on a framing, parity or timeout error

Behaviour:
- **Interface decision:** one clock; reset is synchronous and active-high. Clock port is `clock`, reset port is `reset_`.
- **Reset values:** `mouse_x`=`RESET_X`, `mouse_pressed_`=0, `packet_valid`=0, `frame_error`=0; byte FSM in IDLE; packet index=0. Reset wins over every simultaneous event, including mid-frame.
- **Input conditioning:**
  - `ps2_clk` and `ps2_data` each pass through 2-FF synchronisers.
  - A bit is sampled on a synchronised falling edge of `ps2_clk`: previous=1, current=0.
- **Byte FSM:** IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. If data=1, stay in IDLE and raise no error.
  - DATA: shift in 8 bits, LSB first, one per falling edge. After the 8th bit, go to PARITY.
  - PARITY: sample the parity bit; go to STOP.
  - STOP: sample the stop bit.
    - If stop=1 and the byte is accepted: present the byte to the packet stage in the same cycle.
    - If stop=0: pulse `frame_error` and drop the byte.
    - Return to IDLE in both cases.
  - Timeout: a counter clears on each falling edge and counts while not in IDLE. When it reaches `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_error`, reset packet index to 0.
- **Packet assembly:** index 0/1/2.
  - Byte 0 (flags): bit3 must be 1, else the byte is discarded and the index stays 0 (resync, no error pulse).
    - bit0 = left button.
    - bit4 = X sign.
    - bit6 = X overflow.
  - Byte 1: X magnitude, low 8 bits.
  - Byte 2: Y, ignored.
  - On acceptance of byte 2, in a single cycle:
    - `mouse_pressed_` <= flags bit0.
    - If overflow=0: `mouse_x` <= sat(`mouse_x` + sext9({sign, byte1})). If overflow=1, `mouse_x` is unchanged.
    - `packet_valid` pulses.
    - Index returns to 0.
- **Arithmetic:**
  - Sum computed at 18 bits signed.
  - Result < 0 → 0; result > `MAX_X` → `MAX_X`.
  - No wrap-around ever.
- **Latency:** outputs update 1 cycle after the synchronised falling edge of the final stop bit of byte 2.
- **Error coincidence:** a `frame_error` on any byte resets the packet index to 0. `packet_valid` and `frame_error` never pulse in the same cycle.

Optional Feature:
- Macro: `PS2_PARITY_CHECK_EN`.
- Defined: the parity bit must make the 9 bits (data+parity) odd. On mismatch, the byte is dropped at STOP, `frame_error` pulses and the packet index resets to 0.
- Undefined: the parity bit is sampled but ignored, and no parity errors are raised.

Decomposition:
- Package `mouse_pkg`:
  - enum `ps2_state_t` {IDLE, DATA, PARITY, STOP}.
  - Flag bit-position constants: `FLAG_LEFT`=0, `FLAG_ALWAYS1`=3, `FLAG_XSIGN`=4, `FLAG_XOVF`=6.
  - `PKT_BYTES`=3.
- Sub-module `ps2_byte_receiver`:
  - Contains the synchronisers, edge detect, byte FSM, parity check and timeout.
  - Outputs `byte_data[7:0]`, `byte_valid` and `byte_error`.
- The top level holds packet assembly and the X accumulator.

Test Plan:
- Reset, then packet 0x09, 0x05, 0x00 → `mouse_x` 0→5, `mouse_pressed_`=1, one `packet_valid` pulse.
- From `mouse_x`=3, packet 0x18, 0xFB (−5) → `mouse_x`=0 (low saturation), `mouse_pressed_`=0.
- From `mouse_x`=630, packet 0x08, 0x7F → `mouse_x`=639. Then packet 0x48, 0x10 (overflow) → `mouse_x` stays 639, `packet_valid` still pulses.
- Stray byte 0x00 followed by 0x08, 0x02, 0x00 → first byte discarded, then `mouse_x` += 2, with no `frame_error`.
- Frame stalled after 4 data bits for 5000 cycles → `frame_error` pulse, FSM back in IDLE. Next full packet 0x08, 0x01, 0x00 → `mouse_x` += 1.
- With `PS2_PARITY_CHECK_EN` defined, byte 1 sent with wrong parity → `frame_error`, no `packet_valid`, `mouse_x` unchanged. Without the macro, the same stimulus → `packet_valid` pulses and `mouse_x` updates.
